// File: rtl/tacho_filter.sv
// Fan tachometer conditioner: input synchronizer, glitch filter, pulses-per-rev divider
// and stall detector, configured through a CTRL/STATUS register pair.
module tacho_filter #(
  parameter logic [4:0]  BASE_ADDR = 5'h0,
  parameter int unsigned STALL_SEC = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] csr_a,
  input  logic [7:0] csr_di,
  input  logic       csr_we,
  output logic [7:0] csr_do,
  input  logic       ce_1hz,
  input  logic       tacho_raw,
  output logic       tacho_out,
  output logic       stall_irq
);

  localparam logic [4:0] STATUS_ADDR = BASE_ADDR + 5'd1;
  localparam logic [3:0] STALL_TC    = 4'(STALL_SEC);

  logic [7:0] r_ctrl;
  logic       r_stall;
  logic       r_s1;
  logic       r_s2;
  logic       r_f;
  logic       r_f_d;
  logic [3:0] r_fc;
  logic [1:0] r_pcnt;
  logic       r_tacho;
  logic [3:0] r_st;

  logic       w_en;
  logic [1:0] w_ppr;
  logic       w_ie;
  logic [3:0] w_filt;
  logic       w_ctrl_we;
  logic       w_stat_we;
  logic       w_fr;
  logic       w_ff;
  logic       w_st_hit;

  assign w_en   = r_ctrl[7];
  assign w_ppr  = r_ctrl[6:5];
  assign w_ie   = r_ctrl[4];
  assign w_filt = r_ctrl[3:0];

  assign w_ctrl_we = csr_we && (csr_a == BASE_ADDR);
  assign w_stat_we = csr_we && (csr_a == STATUS_ADDR);

  assign w_fr = w_en & r_f & ~r_f_d;
  assign w_ff = w_en & ~r_f & r_f_d;

  // Set fires on the tick that brings st up to the terminal count; fr pre-empts the tick.
  assign w_st_hit = w_en & ~w_fr & ce_1hz & (r_st == (STALL_TC - 4'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl  <= 8'h00;
      r_stall <= 1'b0;
    end else begin
      if (w_ctrl_we) r_ctrl <= csr_di;
      if (w_st_hit) begin
        r_stall <= 1'b1;
      end else if (w_stat_we && csr_di[0]) begin
        r_stall <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= tacho_raw;
      r_s2 <= r_s1;
    end
  end

  // While disabled both f and its delayed copy follow s, so enabling never sees a fake edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_f   <= 1'b0;
      r_f_d <= 1'b0;
      r_fc  <= 4'd0;
    end else if (!w_en) begin
      r_f   <= r_s2;
      r_f_d <= r_s2;
      r_fc  <= 4'd0;
    end else begin
      r_f_d <= r_f;
      if (r_s2 == r_f) begin
        r_fc <= 4'd0;
      end else if (r_fc == w_filt) begin
        r_f  <= r_s2;
        r_fc <= 4'd0;
      end else begin
        r_fc <= r_fc + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !w_en || w_ctrl_we) begin
      r_pcnt  <= 2'd0;
      r_tacho <= 1'b0;
    end else if (w_fr) begin
      if (r_pcnt == w_ppr) begin
        r_pcnt  <= 2'd0;
        r_tacho <= 1'b1;
      end else begin
        r_pcnt <= r_pcnt + 2'd1;
      end
    end else if (w_ff) begin
      r_tacho <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !w_en || w_fr) begin
      r_st <= 4'd0;
    end else if (ce_1hz && (r_st != STALL_TC)) begin
      r_st <= r_st + 4'd1;
    end
  end

  always_comb begin
    csr_do = 8'h00;
    if (csr_a == BASE_ADDR) begin
      csr_do = r_ctrl;
    end else if (csr_a == STATUS_ADDR) begin
      csr_do = {6'b000000, r_f, r_stall};
    end
  end

  assign tacho_out = r_tacho;
  assign stall_irq = r_stall & w_ie;

endmodule
